trng_entropy_collector: RTL
===========================

// Module: trng_entropy_collector
// PURPOSE
//  Parametrised successor front-end for the TRNG core. Samples ANA_NUM clk-domain entropy channels
//  under a runtime channel mask, either XOR-combines them or serialises them round-robin, and runs a
//  repetition-count health test on the raw bit stream. Packs bits into WORD_W words, buffers them in a
//  FIFO_DEPTH-entry word FIFO, and presents them to postprocess/data_buf over valid/ready.
// PARAMETERS
//  ANA_NUM     8    number of entropy channels (1..16)
//  WORD_W      32   packed output word width (8..256, multiple of 8)
//  FIFO_DEPTH  8    word FIFO entries (power of 2, >=2)
//  WARMUP_BITS 64   bits discarded after every enable before packing starts (0 = none)
// PORTS
//  clk         in   1                       system clock
//  rst         in   1                       synchronous reset, active-high
//  en          in   1                       collector enable
//  ch_mask     in   ANA_NUM                 1 = channel participates; sampled only in IDLE
//  mode        in   1                       0 = XOR combine, 1 = round-robin serialise; sampled only in IDLE
//  ana_data    in   ANA_NUM                 channel data bits (already synchronised to clk)
//  ana_vld     in   ANA_NUM                 one-cycle pulse per channel: ana_data bit valid
//  ht_en       in   1                       health test enable
//  ht_cutoff   in   6                       repetition-count cutoff, 2..63 (0/1 treated as 2)
//  err_clr     in   1                       pulse: clears ht_err and overflow
//  dout        out  WORD_W                  FIFO head word
//  dout_vld    out  1                       FIFO not empty
//  dout_rdy    in   1                       consumer accepts dout when dout_vld & dout_rdy
//  fifo_level  out  $clog2(FIFO_DEPTH+1)    occupied FIFO entries
//  overflow    out  1                       sticky: a completed word was dropped because FIFO full
//  ht_err      out  1                       sticky: repetition-count failure
//  busy        out  1                       FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM=IDLE; pending flags, pack count, RR pointer, RCT count cleared.
//  Per channel: ana_vld[i]&ch_mask_q[i] sets pend[i] and captures ana_data[i]; a new vld on a pending
//   channel overwrites the held bit (no error). Masked channels are ignored.
//  FSM IDLE -> (en & |ch_mask) latch ch_mask_q/mode_q -> WARMUP (or RUN if WARMUP_BITS=0).
//   WARMUP -> RUN after WARMUP_BITS bits produced; any state -> IDLE when en=0 (partial word discarded,
//   pend cleared, FIFO contents kept). en=1 with ch_mask==0 stays IDLE.
//  Bit production (at most 1 bit/cycle): mode 0: when all ch_mask_q channels pending, bit = XOR of
//   held bits, all pend cleared same cycle. mode 1: RR pointer scans from last-served+1; first pending
//   masked channel emits its bit and clears its pend; a pend set and cleared in the same cycle stays set.
//  Health test (WARMUP and RUN, ht_en=1): count consecutive equal bits, count starts at 1; when count
//   reaches cutoff, ht_err<=1 next cycle and count restarts at 1. ht_en=0 holds count at 1.
//  Packing (RUN only): bits shift in LSB-first (first bit -> dout[0]); on WORD_W-th bit the word is
//   pushed the same cycle. Push when full & no pop: word dropped, overflow<=1.
//   Push and pop in the same cycle when full: both succeed, level unchanged.
//  FIFO: first-word latency = 1 cycle after push (dout_vld rises the cycle after the WORD_W-th bit).
//   dout stable while dout_vld & ~dout_rdy.
//  err_clr has priority over a same-cycle set of ht_err/overflow (clear wins).
//  rst mid-operation: everything returns to reset values next cycle, FIFO flushed.
// STRUCTURE
//  trng_pkg: typedef enum {ST_IDLE, ST_WARMUP, ST_RUN} coll_state_t; localparam MODE_XOR=1'b0,
//   MODE_RR=1'b1; localparam HT_CUTOFF_MIN=6'd2.
//  Sub-module trng_word_fifo #(WIDTH, DEPTH): sync FIFO, push/pop/full/empty/level, rst sync active-high.
//  Top: channel capture, combiner/RR arbiter, RCT counter, packer, FSM.
// TESTING
//  1 ANA_NUM=8, mask=8'hFF, mode 0, WARMUP=0, all vld each cycle, data alternating per round
//    -> 1 bit per round; after 32 rounds dout=expected XOR pattern, dout_vld high the next cycle.
//  2 mode 1, mask=8'h05, vld on ch0 and ch2 together each cycle, ch0=1, ch2=0 -> bits 1,0,1,0...;
//    dout=32'h5555_5555.
//  3 ht_en=1, ht_cutoff=6, constant 1s -> ht_err asserts after the 6th equal bit; err_clr -> ht_err=0.
//  4 dout_rdy=0, FIFO_DEPTH=8, fill 9 words -> fifo_level=8, overflow=1, the 8 stored words intact;
//    full with simultaneous push/pop -> level stays 8, overflow unchanged.
//  5 WARMUP_BITS=64: first 64 bits never appear in dout; en dropped mid-word (after 10 bits) then
//    re-raised -> warm-up repeats, first pushed word has no stale bits.
//  6 rst pulse with 3 words queued and partial word -> next cycle dout_vld=0, level=0, busy=0, flags 0.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and constants for the TRNG entropy collector
package trng_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} coll_state_t;

  localparam logic       MODE_XOR      = 1'b0;
  localparam logic       MODE_RR       = 1'b1;
  localparam logic [5:0] HT_CUTOFF_MIN = 6'd2;

endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - synchronous word FIFO; a push into a full FIFO only lands with a same-cycle pop
module trng_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  import trng_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero while empty so dout is clean after reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/trng_entropy_collector.sv
// rtl/trng_entropy_collector.sv - masked channel capture, XOR/round-robin combiner, repetition-count test, word packer
module trng_entropy_collector #(
  parameter int ANA_NUM     = 8,
  parameter int WORD_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int WARMUP_BITS = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [ANA_NUM-1:0]              ch_mask,
  input  logic                            mode,
  input  logic [ANA_NUM-1:0]              ana_data,
  input  logic [ANA_NUM-1:0]              ana_vld,
  input  logic                            ht_en,
  input  logic [5:0]                      ht_cutoff,
  input  logic                            err_clr,
  output logic [WORD_W-1:0]               dout,
  output logic                            dout_vld,
  input  logic                            dout_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  output logic                            ht_err,
  output logic                            busy
);
  import trng_pkg::*;

  localparam int PTR_W  = (ANA_NUM > 1) ? $clog2(ANA_NUM) : 1;
  localparam int PCNT_W = $clog2(WORD_W);
  localparam int WCNT_W = $clog2(WARMUP_BITS + 2);

  coll_state_t       state;
  logic [ANA_NUM-1:0] mask_q;
  logic              mode_q;
  logic [ANA_NUM-1:0] pend;
  logic [ANA_NUM-1:0] held;
  logic [PTR_W-1:0]  rr_next;
  logic [5:0]        rct_cnt;
  logic              last_bit;
  logic [WORD_W-2:0] sh;
  logic [PCNT_W-1:0] pack_cnt;
  logic [WCNT_W-1:0] warm_cnt;

  logic              active;
  logic              bit_vld;
  logic              bit_val;
  logic [ANA_NUM-1:0] clr;
  logic [ANA_NUM-1:0] cap;
  logic [PTR_W-1:0]  rr_sel;
  logic [PTR_W-1:0]  idx;
  int                sum;
  logic [5:0]        cutoff_eff;
  logic [5:0]        rct_next;
  logic              rct_hit;
  logic              pack_bit;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;
  logic              fifo_empty;

  assign active = en && (state != ST_IDLE);
  assign cap    = ana_vld & mask_q;

  // Bit source: XOR waits for every enabled channel, round-robin takes the first pending one.
  always_comb begin
    bit_vld = 1'b0;
    bit_val = 1'b0;
    clr     = '0;
    rr_sel  = rr_next;
    idx     = '0;
    sum     = 0;
    if (active) begin
      if (mode_q == MODE_XOR) begin
        if ((pend & mask_q) == mask_q) begin
          bit_vld = 1'b1;
          bit_val = ^(held & mask_q);
          clr     = mask_q;
        end
      end else begin
        for (int i = 0; i < ANA_NUM; i++) begin
          sum = int'(rr_next) + i;
          if (sum >= ANA_NUM) sum = sum - ANA_NUM;
          idx = PTR_W'(sum);
          if (!bit_vld && pend[idx]) begin
            bit_vld  = 1'b1;
            bit_val  = held[idx];
            clr[idx] = 1'b1;
            rr_sel   = idx;
          end
        end
      end
    end
  end

  assign cutoff_eff = (ht_cutoff < HT_CUTOFF_MIN) ? HT_CUTOFF_MIN : ht_cutoff;

  // A count of zero means no bit seen yet this session.
  always_comb begin
    rct_next = rct_cnt;
    rct_hit  = 1'b0;
    if (bit_vld) begin
      if (!ht_en) begin
        rct_next = 6'd1;
      end else begin
        rct_next = (rct_cnt != 6'd0 && bit_val == last_bit) ? rct_cnt + 6'd1 : 6'd1;
        if (rct_next >= cutoff_eff) begin
          rct_hit  = 1'b1;
          rct_next = 6'd1;
        end
      end
    end
  end

  assign pack_bit  = bit_vld && (state == ST_RUN);
  assign push      = pack_bit && (pack_cnt == PCNT_W'(WORD_W - 1));
  assign push_word = {bit_val, sh};

  trng_word_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (dout_rdy),
    .head      (dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign dout_vld = !fifo_empty;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      mode_q   <= MODE_XOR;
      pend     <= '0;
      held     <= '0;
      rr_next  <= '0;
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      sh       <= '0;
      pack_cnt <= '0;
      warm_cnt <= '0;
      ht_err   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (err_clr)      ht_err <= 1'b0;
      else if (rct_hit) ht_err <= 1'b1;

      if (err_clr)                                        overflow <= 1'b0;
      else if (push && fifo_full && !(dout_rdy && dout_vld)) overflow <= 1'b1;

      // A capture in the same cycle as a consume keeps the channel pending.
      if (active) begin
        pend <= (pend & ~clr) | cap;
        held <= (held & ~cap) | (ana_data & cap);
      end else begin
        pend <= '0;
      end

      if (bit_vld) begin
        last_bit <= bit_val;
        rct_cnt  <= rct_next;
        if (mode_q == MODE_RR)
          rr_next <= (rr_sel == PTR_W'(ANA_NUM - 1)) ? '0 : rr_sel + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          pack_cnt <= '0;
          warm_cnt <= '0;
          rct_cnt  <= '0;
          if (en && |ch_mask) begin
            mask_q <= ch_mask;
            mode_q <= mode;
            state  <= (WARMUP_BITS == 0) ? ST_RUN : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (bit_vld) begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WCNT_W'(WARMUP_BITS - 1)) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state    <= ST_IDLE;
            pack_cnt <= '0;
          end else if (pack_bit) begin
            sh       <= {bit_val, sh[WORD_W-2:1]};
            pack_cnt <= push ? '0 : pack_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
